// File: rtl/db_multi.sv
// Multi-channel switch debouncer: per-channel synchronizer, four-state settle FSM,
// registered level with one-cycle rise/fall ticks and a combined tick flag.
module db_multi #(
    parameter int CH          = 8,
    parameter int N           = 21,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [CH-1:0] sw,
    input  logic [N-1:0]  limit,
    output logic [CH-1:0] db_level,
    output logic [CH-1:0] db_rise,
    output logic [CH-1:0] db_fall,
    output logic          any_tick
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DLY0 = 2'b01,
        ONE  = 2'b10,
        DLY1 = 2'b11
    } state_t;

    logic [CH-1:0] sync_q [SYNC_STAGES];
    logic [CH-1:0] sync_d [SYNC_STAGES];
    logic [CH-1:0] s;

    state_t        state_q [CH];
    state_t        state_d [CH];
    logic [N-1:0]  timer_q [CH];
    logic [N-1:0]  timer_d [CH];

    logic [CH-1:0] level_q, level_d;
    logic [CH-1:0] rise_q, rise_d;
    logic [CH-1:0] fall_q, fall_d;
    logic          any_q, any_d;

    always_comb begin
        sync_d[0] = sw;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Settle timer stops advancing once it reaches limit, so it can never wrap.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            case (state_q[i])
                IDLE: begin
                    if (s[i]) begin
                        timer_d[i] = '0;
                        state_d[i] = DLY0;
                    end
                end
                DLY0: begin
                    if (!s[i]) begin
                        state_d[i] = IDLE;
                    end else if (timer_q[i] >= limit) begin
                        state_d[i] = ONE;
                    end else begin
                        timer_d[i] = timer_q[i] + N'(1);
                    end
                end
                ONE: begin
                    if (!s[i]) begin
                        timer_d[i] = '0;
                        state_d[i] = DLY1;
                    end
                end
                DLY1: begin
                    if (s[i]) begin
                        state_d[i] = ONE;
                    end else if (timer_q[i] >= limit) begin
                        state_d[i] = IDLE;
                    end else begin
                        timer_d[i] = timer_q[i] + N'(1);
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state flop.
    always_comb begin
        level_d = '0;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < CH; i++) begin
            level_d[i] = (state_d[i] == ONE) || (state_d[i] == DLY1);
            rise_d[i]  = (state_q[i] == DLY0) && (state_d[i] == ONE);
            fall_d[i]  = (state_q[i] == DLY1) && (state_d[i] == IDLE);
        end
        any_d = (|rise_d) | (|fall_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= IDLE;
                timer_q[i] <= '0;
            end
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            any_q   <= 1'b0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            any_q   <= any_d;
        end
    end

    assign db_level = level_q;
    assign db_rise  = rise_q;
    assign db_fall  = fall_q;
    assign any_tick = any_q;

endmodule
